// File: rtl/ysyx_25060170_rf_pkg.sv
// rtl/ysyx_25060170_rf_pkg.sv - shared constants, index type and helpers for the GPR file
package ysyx_25060170_rf_pkg;

    localparam int REG_AW     = 5;
    localparam int XLEN_DEF   = 32;
    localparam int NR_REG_DEF = 32;

    typedef logic [REG_AW-1:0] reg_idx_t;

    localparam reg_idx_t REG_ZERO = 5'd0;
    localparam reg_idx_t REG_RA   = 5'd1;
    localparam reg_idx_t REG_SP   = 5'd2;

    // True for an index that names a stored register (not x0, below NR_REG)
    function automatic logic reg_valid(input reg_idx_t idx, input int nr);
        return (idx != REG_ZERO) && (int'(idx) < nr);
    endfunction

endpackage

// File: rtl/ysyx_25060170_scoreboard.sv
// rtl/ysyx_25060170_scoreboard.sv - busy vector and RAW/WAW hazard detection (YSYX_25060170_RF_BYPASS_EN)
module ysyx_25060170_scoreboard
    import ysyx_25060170_rf_pkg::*;
#(
    parameter int NR_REG = NR_REG_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wen_i,
    input  logic [4:0]        waddr_i,
    input  logic [4:0]        raddr1_i,
    input  logic [4:0]        raddr2_i,
    input  logic              issue_valid_i,
    input  logic              issue_wen_i,
    input  logic [4:0]        issue_rd_i,
    output logic              stall_o,
    output logic [NR_REG-1:0] busy_o
);

    logic [NR_REG-1:0] busy_q;
    logic [NR_REG-1:0] set_mask;
    logic [NR_REG-1:0] clr_mask;
    logic [31:0]       hz_vec;
    logic              do_set;
    logic              do_clr;

    assign do_set = issue_valid_i && issue_wen_i && !stall_o && (issue_rd_i != REG_ZERO);
    assign do_clr = wen_i && (waddr_i != REG_ZERO);

    // Per-index set/clear strobes; x0 never gets a set because do_set excludes it
    for (genvar i = 0; i < NR_REG; i++) begin : g_mask
        assign set_mask[i] = do_set && (issue_rd_i == 5'(i));
        assign clr_mask[i] = do_clr && (waddr_i == 5'(i));
    end

    // Hazard per architectural index; x0 and indices beyond NR_REG never stall
    for (genvar i = 0; i < 32; i++) begin : g_hz
        if (i == 0 || i >= NR_REG) begin : g_none
            assign hz_vec[i] = 1'b0;
        end else begin : g_reg
`ifdef YSYX_25060170_RF_BYPASS_EN
            assign hz_vec[i] = busy_q[i] && !(wen_i && (waddr_i == 5'(i)));
`else
            assign hz_vec[i] = busy_q[i];
`endif
        end
    end

    assign stall_o = !rst && issue_valid_i &&
                     (hz_vec[raddr1_i] || hz_vec[raddr2_i] || (issue_wen_i && hz_vec[issue_rd_i]));

    // Busy update: clear on write-back, then set on issue so the newer owner wins
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= (busy_q & ~clr_mask) | set_mask;
        end
    end

    assign busy_o = busy_q;

endmodule

// File: rtl/ysyx_25060170_rf.sv
// rtl/ysyx_25060170_rf.sv - GPR file with issue scoreboard, optional write-to-read forwarding (YSYX_25060170_RF_BYPASS_EN)
module ysyx_25060170_rf
    import ysyx_25060170_rf_pkg::*;
#(
    parameter int NR_REG = NR_REG_DEF,
    parameter int XLEN   = XLEN_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wen_i,
    input  logic [4:0]        waddr_i,
    input  logic [XLEN-1:0]   wdata_i,
    input  logic [4:0]        raddr1_i,
    input  logic [4:0]        raddr2_i,
    output logic [XLEN-1:0]   rdata1_o,
    output logic [XLEN-1:0]   rdata2_o,
    input  logic              issue_valid_i,
    input  logic              issue_wen_i,
    input  logic [4:0]        issue_rd_i,
    output logic              stall_o,
    output logic [NR_REG-1:0] busy_o
);

    // x0 is hardwired, so storage starts at index 1
    logic [XLEN-1:0] regs [1:NR_REG-1];

    // Write-back into the array; x0 and out-of-range indices are dropped
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 1; i < NR_REG; i++) begin
                regs[i] <= '0;
            end
        end else if (wen_i && reg_valid(waddr_i, NR_REG)) begin
            regs[waddr_i] <= wdata_i;
        end
    end

    // rs1 read mux, with same-cycle forwarding of the write-back value when enabled
    always_comb begin
        rdata1_o = '0;
        if (reg_valid(raddr1_i, NR_REG)) begin
            rdata1_o = regs[raddr1_i];
        end
`ifdef YSYX_25060170_RF_BYPASS_EN
        if (wen_i && (waddr_i == raddr1_i) && (raddr1_i != REG_ZERO)) begin
            rdata1_o = wdata_i;
        end
`endif
    end

    // rs2 read mux, mirror of rs1
    always_comb begin
        rdata2_o = '0;
        if (reg_valid(raddr2_i, NR_REG)) begin
            rdata2_o = regs[raddr2_i];
        end
`ifdef YSYX_25060170_RF_BYPASS_EN
        if (wen_i && (waddr_i == raddr2_i) && (raddr2_i != REG_ZERO)) begin
            rdata2_o = wdata_i;
        end
`endif
    end

    ysyx_25060170_scoreboard #(
        .NR_REG (NR_REG)
    ) u_scoreboard (
        .clk           (clk),
        .rst           (rst),
        .wen_i         (wen_i),
        .waddr_i       (waddr_i),
        .raddr1_i      (raddr1_i),
        .raddr2_i      (raddr2_i),
        .issue_valid_i (issue_valid_i),
        .issue_wen_i   (issue_wen_i),
        .issue_rd_i    (issue_rd_i),
        .stall_o       (stall_o),
        .busy_o        (busy_o)
    );

endmodule

// File: doc/ysyx_25060170_rf.md
# ysyx_25060170_rf

Architectural integer register file with an in-order issue scoreboard; it is the write-back endpoint of the pipeline. It accepts the write-back port (data/address/enable) and holds the 32 GPRs. It serves the two IDU read ports and tracks which destination registers have writes still in flight, so that IDU can stall on RAW/WAW hazards. Sits between IDU (read/issue side) and WBU (write side).

## Interface
- `NR_REG`, 32, number of GPRs (16 permitted for RV32E; index width stays 5)
- `XLEN`, 32, register width
- `clk` input 1 — system clock, all state updates on rising edge
- `rst` input 1 — synchronous, active-high reset
- `wen_i` input 1 — write-back enable from WBU
- `waddr_i` input 5 — write-back register index
- `wdata_i` input XLEN — write-back data
- `raddr1_i` input 5 — rs1 index of the instruction in IDU
- `raddr2_i` input 5 — rs2 index of the instruction in IDU
- `rdata1_o` output XLEN — rs1 value
- `rdata2_o` output XLEN — rs2 value
- `issue_valid_i` input 1 — IDU presents an instruction for issue this cycle
- `issue_wen_i` input 1 — that instruction writes rd
- `issue_rd_i` input 5 — its rd
- `stall_o` output 1 — issue blocked by a hazard; IDU must hold the instruction
- `busy_o` output NR_REG — scoreboard bit vector, bit i = write to xi pending

## Operation
- Storage: regs[1..NR_REG-1]; x0 is not stored and always reads 0.
- Write:
  - At the clock edge, if `wen_i && waddr_i != 0 && waddr_i < NR_REG`, then regs[waddr_i] <= wdata_i.
  - Writes to x0 or to an out-of-range index are dropped silently.
- Read: combinational.
  - `rdata*_o` = 0 if the address is 0 or ≥ NR_REG; otherwise regs[addr] (bypass rules are in Configuration).
- Scoreboard set: at the edge, busy[issue_rd_i] <= 1 when all of the following hold:
  - `issue_valid_i && issue_wen_i && !stall_o`
  - `issue_rd_i != 0`
- Scoreboard clear: at the edge, busy[waddr_i] <= 0 when `wen_i && waddr_i != 0`.
- Set and clear on the same index in the same cycle: set wins, because the newer instruction owns the register.
- busy[0] is constant 0.
- Hazard: `stall_o = issue_valid_i && (hz(raddr1_i) || hz(raddr2_i) || (issue_wen_i && hz(issue_rd_i)))`.
  - hz(r) = busy[r], with the write-back-cycle exception described in Configuration.
  - Index 0 never causes a hazard.
- Unused source fields (for example U-type rs1) are decoded to 0 by IDU so that they do not cause false stalls.
- A write-back to a register whose busy bit is 0 is legal: it updates the register and busy stays 0.

## Timing
- Read latency: 0 cycles (combinational).
- Write visibility through regs: the cycle after `wen_i`.
- Scoreboard bit visibility: the cycle after the issue edge.
- Reset values: all regs = 0, busy_o = 0.
  - While `rst` is high, `stall_o` = 0 and writes and issues are ignored.
  - Reset asserted mid-flight discards all pending busy bits.
- `stall_o` is combinational from the inputs and busy; it carries no registered delay.

## Configuration
- `YSYX_25060170_RF_BYPASS_EN` defined:
  - Write-to-read forwarding: if `wen_i && waddr_i == raddrN_i && raddrN_i != 0`, then `rdataN_o = wdata_i`.
  - hz(r) = busy[r] && !(wen_i && waddr_i == r), so the dependent instruction issues in the write-back cycle.
- Macro undefined:
  - Reads return only regs.
  - hz(r) = busy[r], so the dependent instruction issues one cycle after write-back.

## Structure
- The shared package holds:
  - the register-index width constant (5)
  - XLEN
  - the NR_REG default
  - the ABI index constants (REG_ZERO = 0, REG_RA = 1, REG_SP = 2)
- One sub-module, `ysyx_25060170_scoreboard`, owns the busy vector and the set/clear/hazard logic.
  - It takes the write-back port and the issue port.
  - It outputs busy_o and stall_o.
- The register array and the read muxes stay in the top module.

## Test plan
- Reset, then write x5 = 0xDEADBEEF, then read raddr1 = 5 on the next cycle -> rdata1_o = 0xDEADBEEF; read raddr2 = 0 -> rdata2_o = 0.
- Write x0 = 0x12345678 -> rdata of x0 stays 0; busy_o[0] stays 0.
- Issue with rd = 7 -> busy_o = 0x80. The next instruction with rs1 = 7 -> stall_o = 1 until write-back of x7.
  - With bypass: stall_o = 0 in the write-back cycle and rdata1_o = wdata_i.
  - Without bypass: stall_o = 0 the cycle after write-back.
- Same cycle: write-back to x3 and issue with rd = 3 -> busy_o[3] = 1 afterwards; regs[3] = new wdata.
- Stalled issue (rs2 busy) with rd = 9 -> busy_o[9] remains 0.
- busy_o = 0x0000_0300, then assert rst for 1 cycle -> busy_o = 0, stall_o = 0, and every register reads 0.
